// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_pkg: shared constants, requester ids and FSM states for the register-file write arbiter.
package regfile_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LOAD = 1'b1;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: two writeback request channels plus the register-file write port.
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
);
  logic req0_valid;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic req0_ready;
  logic req1_valid;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic req1_ready;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic reg_write;
  logic grant_id;
  logic init_done;
  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input req0_ready, req1_ready, write_reg, write_data, reg_write, grant_id, init_done
  );
  modport slave (
    input req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready, write_reg, write_data, reg_write, grant_id, init_done
  );
endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// rr_arbiter2: two-way round-robin arbiter; ptr names the requester favoured on a tie.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);
  logic ptr;
  assign grant[0] = en & valid[0] & (~valid[1] | (ptr == REQ_ALU));
  assign grant[1] = en & valid[1] & (~valid[0] | (ptr == REQ_LOAD));
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= REQ_ALU;
    else if (grant[0]) ptr <= REQ_LOAD;
    else if (grant[1]) ptr <= REQ_ALU;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: zero-fills x1..x(N-1) after reset, then round-robin shares the
// register-file write port between ALU and load writeback with one cycle of latency.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  state_t state, state_d;
  logic [ADDR_W-1:0] init_cnt;
  logic [1:0] grant;
  logic [ADDR_W-1:0] acc_reg;
  logic [DATA_W-1:0] acc_data;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic reg_write, grant_id, init_done;
  rr_arbiter2 u_arb (
    .clk(clk),
    .reset(reset),
    .en(state == ST_RUN),
    .valid({bus.req1_valid, bus.req0_valid}),
    .grant(grant)
  );
  assign acc_reg = grant[1] ? bus.req1_reg : bus.req0_reg;
  assign acc_data = grant[1] ? bus.req1_data : bus.req0_data;
  always_comb begin
    state_d = state;
    if (state == ST_INIT && init_cnt == LAST) state_d = ST_RUN;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= INIT_ON_RESET ? ST_INIT : ST_RUN;
    else state <= state_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reg_write <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      grant_id <= REQ_ALU;
      init_done <= !INIT_ON_RESET;
      init_cnt <= ADDR_W'(1);
    end else if (state == ST_INIT) begin
      reg_write <= 1'b1;
      write_reg <= init_cnt;
      write_data <= '0;
      grant_id <= REQ_ALU;
      init_cnt <= init_cnt + 1'b1;
      init_done <= init_cnt == LAST;
    end else begin
      // x0 writes consume the grant but never reach the port
      reg_write <= (|grant) && acc_reg != '0;
      if ((|grant) && acc_reg != '0) begin
        write_reg <= acc_reg;
        write_data <= acc_data;
        grant_id <= grant[1] ? REQ_LOAD : REQ_ALU;
      end
    end
  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];
  assign bus.write_reg = write_reg;
  assign bus.write_data = write_data;
  assign bus.reg_write = reg_write;
  assign bus.grant_id = grant_id;
  assign bus.init_done = init_done;
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Sequences and shares the single write port of register_file (write_reg, write_data, reg_write) between two writeback requesters: req0 = ALU writeback, req1 = load/memory writeback. After reset it runs an init sequence that zero-fills x1..x31. After that it round-robin arbitrates valid/ready requests and drives the register-file write port one cycle after acceptance. Writes to x0 are accepted and dropped.

Parameters:
NUM_REGS, 32, number of architectural registers; must be 2**ADDR_W
ADDR_W, 5, register index width
DATA_W, 32, register data width
INIT_ON_RESET, 1, 1 = zero-fill x1..x(NUM_REGS-1) after reset; 0 = enter RUN directly

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req0_valid  input  1  ALU writeback request
req0_reg  input  ADDR_W  ALU destination register
req0_data  input  DATA_W  ALU writeback data
req0_ready  output  1  req0 accepted this cycle
req1_valid  input  1  load writeback request
req1_reg  input  ADDR_W  load destination register
req1_data  input  DATA_W  load writeback data
req1_ready  output  1  req1 accepted this cycle
write_reg  output  ADDR_W  to register_file.write_reg
write_data  output  DATA_W  to register_file.write_data
reg_write  output  1  to register_file.reg_write
grant_id  output  1  requester of the write currently on the port (0/1)
init_done  output  1  high once the init fill is complete

Behaviour:
- Reset (reset=0, asynchronous): reg_write=0, write_reg=0, write_data=0, grant_id=0, init_done=0, rr_ptr=0 (req0 favoured), init_cnt=1, state=INIT. If INIT_ON_RESET=0, state=RUN and init_done=1.
- States: INIT, RUN. No other states. RUN is terminal until the next reset.
- INIT:
  - Each cycle register reg_write=1, write_reg=init_cnt, write_data=0, grant_id=0.
  - init_cnt increments 1..NUM_REGS-1.
  - The cycle that issues init_cnt=NUM_REGS-1 moves to RUN. init_done rises on the same edge. Total init = NUM_REGS-1 cycles.
  - req0_ready=req1_ready=0 throughout INIT.
  - Reset asserted mid-INIT restarts the fill at x1.
- RUN arbitration (combinational readies):
  - Only req0_valid: req0_ready=1.
  - Only req1_valid: req1_ready=1.
  - Both valid: the requester favoured by rr_ptr gets ready; the other gets ready=0.
  - Neither valid: both readies 0.
  - At most one ready is high per cycle.
  - On every accept (valid & ready), rr_ptr <= the non-granted id.
  - Requesters hold valid and payload stable until accepted. valid must not depend on ready.
- Output timing: 1-cycle latency from accept edge to port.
  - Accept with reg≠0: next cycle reg_write=1, write_reg/write_data = payload, grant_id = granted id.
  - Accept with reg=0: consumes the grant and advances rr_ptr. Next cycle reg_write=0; write_reg/write_data/grant_id hold their previous values.
  - No accept: reg_write=0 the next cycle; other outputs hold.
- Throughput: one write per cycle sustained.
- Same destination from both requesters: writes are serialized in grant order, so the later grant's data is final.
- No internal storage beyond the single output register. Backpressure applies only via ready.

Decomposition:
- Shared package regfile_pkg:
  - ADDR_W and DATA_W constants
  - requester id constants REQ_ALU=0, REQ_LOAD=1
  - state enum {ST_INIT, ST_RUN}
- Sub-module rr_arbiter2 (2-way round-robin: valid[1:0], accept → grant[1:0], ptr update). The rest stays flat.
- Integration: the top level instantiates regfile_write_arbiter directly in front of register_file.

Test Plan:
- Reset released, INIT_ON_RESET=1 → reg_write=1 for 31 consecutive cycles with write_reg 1..31 and write_data 0. init_done=1 after the 31st. Readies 0 throughout. Readback of x1 = 0.
- RUN, req0_valid only, reg=1, data=32'hA5A5A5A5 → req0_ready=1 same cycle. Next cycle: reg_write=1, write_reg=1, write_data=A5A5A5A5, grant_id=0. read_data1 of x1 = A5A5A5A5.
- Both valid for 4 cycles (req0: x2 ← 12345678; req1: x3 ← DEADBEEF, payloads held until accepted, then new payloads x4/x5) → grants alternate 0,1,0,1 starting with req0. One reg_write per cycle, no drops.
- req1_valid with reg=0, data=FFFFFFFF → req1_ready=1. Next cycle reg_write=0. rr_ptr now favours req0. Readback of x0 = 0.
- Reset pulled low at INIT cycle 10, released 2 cycles later → outputs immediately 0. Fill restarts at write_reg=1 and takes 31 further cycles before init_done=1.
